// File: rtl/cpu_pkg.sv
// Shared CPU encodings: ALU op codes, MIPS opcode/funct constants and the
// decode records exchanged between the decode table, decode register and ALU.
package cpu_pkg;

    typedef enum logic [3:0] {
        ALU_ADDU = 4'b0000,
        ALU_SUBU = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0011,
        ALU_AND  = 4'b0100,
        ALU_OR   = 4'b0101,
        ALU_XOR  = 4'b0110,
        ALU_NOR  = 4'b0111,
        ALU_LUI  = 4'b1000,
        ALU_BGEZ = 4'b1001,
        ALU_SLTU = 4'b1010,
        ALU_SLT  = 4'b1011,
        ALU_SRA  = 4'b1100,
        ALU_SRL  = 4'b1101,
        ALU_SLL  = 4'b1110
    } aluc_e;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [4:0] RT_BGEZ = 5'd1;

    // uses_rs/uses_rt mark the register operands an instruction actually reads.
    typedef struct packed {
        aluc_e       aluc;
        logic        asel;
        logic        bsel;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        wen;
        logic        mem_rd;
        logic        mem_wr;
        logic        illegal;
        logic        uses_rs;
        logic        uses_rt;
    } decode_t;

    typedef struct packed {
        logic        valid;
        aluc_e       aluc;
        logic        asel;
        logic        bsel;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        wen;
        logic        mem_rd;
        logic        mem_wr;
        logic        illegal;
    } id_out_t;

endpackage

// File: rtl/id_decode_if.sv
// Fetch-to-EX bundle around the decode stage: fetch handshake, decoded
// instruction towards EX, flush and the EX load hazard sideband.
interface id_decode_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_aluc;
    logic        out_asel;
    logic        out_bsel;
    logic [31:0] out_imm;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        out_mem_rd;
    logic        out_mem_wr;
    logic        out_illegal;
    logic        flush;
    logic        ex_load;
    logic [4:0]  ex_rd;

    modport master (
        output in_valid, in_instr, out_ready, flush, ex_load, ex_rd,
        input  in_ready, out_valid, out_aluc, out_asel, out_bsel, out_imm,
               out_rs, out_rt, out_rd, out_wen, out_mem_rd, out_mem_wr, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, out_ready, flush, ex_load, ex_rd,
        output in_ready, out_valid, out_aluc, out_asel, out_bsel, out_imm,
               out_rs, out_rt, out_rd, out_wen, out_mem_rd, out_mem_wr, out_illegal
    );
endinterface

// File: rtl/id_decode_tbl.sv
// Purely combinational MIPS decode table: instruction word to ALU controls,
// extended immediate, destination and memory/write-enable flags.
module id_decode_tbl
    import cpu_pkg::*;
(
    input  logic [31:0] instr,
    output decode_t     dec
);
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic        illegal;
    logic        itype;
    logic        branch;
    logic        sext;
    logic        writes;

    assign opcode   = instr[31:26];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign shamt    = instr[10:6];
    assign funct    = instr[5:0];
    assign imm_sext = {{16{instr[15]}}, instr[15:0]};
    assign imm_zext = {16'd0, instr[15:0]};

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
        dec     = '0;
        illegal = 1'b0;
        itype   = 1'b0;
        branch  = 1'b0;
        sext    = 1'b1;
        writes  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dec.rd      = rd;
                dec.imm     = {27'd0, shamt};
                dec.uses_rs = 1'b1;
                dec.uses_rt = 1'b1;
                writes      = 1'b1;
                case (funct)
                    FN_ADD:  dec.aluc = ALU_ADD;
                    FN_ADDU: dec.aluc = ALU_ADDU;
                    FN_SUB:  dec.aluc = ALU_SUB;
                    FN_SUBU: dec.aluc = ALU_SUBU;
                    FN_AND:  dec.aluc = ALU_AND;
                    FN_OR:   dec.aluc = ALU_OR;
                    FN_XOR:  dec.aluc = ALU_XOR;
                    FN_NOR:  dec.aluc = ALU_NOR;
                    FN_SLT:  dec.aluc = ALU_SLT;
                    FN_SLTU: dec.aluc = ALU_SLTU;
                    FN_SLL:  begin dec.aluc = ALU_SLL; dec.asel = 1'b1; dec.uses_rs = 1'b0; end
                    FN_SRL:  begin dec.aluc = ALU_SRL; dec.asel = 1'b1; dec.uses_rs = 1'b0; end
                    FN_SRA:  begin dec.aluc = ALU_SRA; dec.asel = 1'b1; dec.uses_rs = 1'b0; end
                    FN_SLLV: dec.aluc = ALU_SLL;
                    FN_SRLV: dec.aluc = ALU_SRL;
                    FN_SRAV: dec.aluc = ALU_SRA;
                    default: illegal  = 1'b1;
                endcase
            end
            OP_ADDI:  begin itype = 1'b1; dec.aluc = ALU_ADD;  end
            OP_ADDIU: begin itype = 1'b1; dec.aluc = ALU_ADDU; end
            OP_SLTI:  begin itype = 1'b1; dec.aluc = ALU_SLT;  end
            OP_SLTIU: begin itype = 1'b1; dec.aluc = ALU_SLTU; end
            OP_LW:    begin itype = 1'b1; dec.aluc = ALU_ADDU; dec.mem_rd = 1'b1; end
            OP_SW:    begin itype = 1'b1; dec.aluc = ALU_ADDU; dec.mem_wr = 1'b1; end
            OP_ANDI:  begin itype = 1'b1; sext = 1'b0; dec.aluc = ALU_AND; end
            OP_ORI:   begin itype = 1'b1; sext = 1'b0; dec.aluc = ALU_OR;  end
            OP_XORI:  begin itype = 1'b1; sext = 1'b0; dec.aluc = ALU_XOR; end
            OP_LUI:   begin itype = 1'b1; sext = 1'b0; dec.aluc = ALU_LUI; end
            OP_BEQ, OP_BNE: begin
                branch      = 1'b1;
                dec.aluc    = ALU_SUBU;
                dec.uses_rs = 1'b1;
                dec.uses_rt = 1'b1;
            end
            OP_REGIMM: begin
                branch      = 1'b1;
                dec.aluc    = ALU_BGEZ;
                dec.uses_rs = 1'b1;
                illegal     = (rt != RT_BGEZ);
            end
            default: illegal = 1'b1;
        endcase

        // lui carries the raw zero-extended half; the ALU does the shift by 16.
        if (itype) begin
            dec.bsel    = 1'b1;
            dec.uses_rs = (opcode != OP_LUI);
            dec.uses_rt = dec.mem_wr;
            writes      = !dec.mem_wr;
        end
        if (itype || branch) begin
            dec.rd  = rt;
            dec.imm = sext ? imm_sext : imm_zext;
        end
        dec.wen = writes && (dec.rd != 5'd0);

        if (illegal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end
endmodule

// File: rtl/id_decode.sv
// Decode stage: one registered decoded instruction behind a valid/ready
// handshake with flush; defining ID_LOAD_USE_STALL_EN adds a load-use stall.
module id_decode
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    id_decode_if.slave bus
);
    decode_t    dec;
    id_out_t    out_q;
    id_out_t    out_d;
    logic       stall;
    logic       in_ready;
    logic       accept;
    logic [4:0] in_rs;
    logic [4:0] in_rt;

    assign in_rs = bus.in_instr[25:21];
    assign in_rt = bus.in_instr[20:16];

    id_decode_tbl u_tbl (
        .instr (bus.in_instr),
        .dec   (dec)
    );

`ifdef ID_LOAD_USE_STALL_EN
    assign stall = bus.ex_load && (bus.ex_rd != 5'd0) &&
                   ((dec.uses_rs && (bus.ex_rd == in_rs)) ||
                    (dec.uses_rt && (bus.ex_rd == in_rt)));
`else
    logic unused_hazard;
    assign stall         = 1'b0;
    assign unused_hazard = ^{bus.ex_load, bus.ex_rd, dec.uses_rs, dec.uses_rt};
`endif

    // Flush opens the input so fetch can drain, but that cycle's word is dropped.
    always_comb begin
        if (rst) begin
            in_ready = 1'b0;
        end else if (bus.flush) begin
            in_ready = 1'b1;
        end else begin
            in_ready = (!out_q.valid || bus.out_ready) && !stall;
        end
    end

    assign accept = bus.in_valid && in_ready && !bus.flush;

    always_comb begin
        out_d = out_q;
        if (bus.flush) begin
            out_d.valid = 1'b0;
        end else if (accept) begin
            out_d.valid   = 1'b1;
            out_d.aluc    = dec.aluc;
            out_d.asel    = dec.asel;
            out_d.bsel    = dec.bsel;
            out_d.imm     = dec.imm;
            out_d.rs      = in_rs;
            out_d.rt      = in_rt;
            out_d.rd      = dec.rd;
            out_d.wen     = dec.wen;
            out_d.mem_rd  = dec.mem_rd;
            out_d.mem_wr  = dec.mem_wr;
            out_d.illegal = dec.illegal;
        end else if (bus.out_ready) begin
            out_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_q.valid;
    assign bus.out_aluc    = out_q.aluc;
    assign bus.out_asel    = out_q.asel;
    assign bus.out_bsel    = out_q.bsel;
    assign bus.out_imm     = out_q.imm;
    assign bus.out_rs      = out_q.rs;
    assign bus.out_rt      = out_q.rt;
    assign bus.out_rd      = out_q.rd;
    assign bus.out_wen     = out_q.wen;
    assign bus.out_mem_rd  = out_q.mem_rd;
    assign bus.out_mem_wr  = out_q.mem_wr;
    assign bus.out_illegal = out_q.illegal;
endmodule

// File: tb/tb_id_decode.sv
// Directed bench for id_decode: a decode vector table plus hand-written
// sequences for reset, back-pressure hold, flush and the load-use stall.
module tb_id_decode;
    logic clk;
    logic rst;

    id_decode_if bus ();

    id_decode u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [3:0]  aluc;
        logic        asel;
        logic        bsel;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        wen;
        logic        mrd;
        logic        mwr;
        logic        ill;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_err;

    function automatic vec_t mk(string name, logic [31:0] instr, logic [3:0] aluc,
                                logic asel, logic bsel, logic [31:0] imm,
                                logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                logic wen, logic mrd, logic mwr, logic ill);
        vec_t v;
        v.name = name; v.instr = instr; v.aluc = aluc; v.asel = asel; v.bsel = bsel;
        v.imm = imm; v.rs = rs; v.rt = rt; v.rd = rd;
        v.wen = wen; v.mrd = mrd; v.mwr = mwr; v.ill = ill;
        return v;
    endfunction

    function automatic logic [63:0] exp_bundle(vec_t v);
        return {6'd0, 1'b1, v.aluc, v.asel, v.bsel, v.imm, v.rs, v.rt, v.rd,
                v.wen, v.mrd, v.mwr, v.ill};
    endfunction

    function automatic logic [63:0] act_bundle();
        return {6'd0, bus.out_valid, bus.out_aluc, bus.out_asel, bus.out_bsel, bus.out_imm,
                bus.out_rs, bus.out_rt, bus.out_rd, bus.out_wen, bus.out_mem_rd,
                bus.out_mem_wr, bus.out_illegal};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t v_lui;
    vec_t v_addu;
    vec_t v_hz;
    vec_t v_sw;

    initial begin
        n_vec = 0;
        n_err = 0;
        //             name        instr         aluc     as    bs    imm           rs     rt     rd     wen   mrd   mwr   ill
        vecs.push_back(mk("addu",  32'h00221821, 4'b0000, 1'b0, 1'b0, 32'h00000000, 5'd1,  5'd2,  5'd3,  1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("sra",   32'h000521C3, 4'b1100, 1'b1, 1'b0, 32'h00000007, 5'd0,  5'd5,  5'd4,  1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("ori",   32'h34068001, 4'b0101, 1'b0, 1'b1, 32'h00008001, 5'd0,  5'd6,  5'd6,  1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("addi",  32'h2128FFFC, 4'b0010, 1'b0, 1'b1, 32'hFFFFFFFC, 5'd9,  5'd8,  5'd8,  1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("lw",    32'h8FAA0010, 4'b0000, 1'b0, 1'b1, 32'h00000010, 5'd29, 5'd10, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("sw",    32'hAFABFFF8, 4'b0000, 1'b0, 1'b1, 32'hFFFFFFF8, 5'd29, 5'd11, 5'd11, 1'b0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk("beq",   32'h10220003, 4'b0001, 1'b0, 1'b0, 32'h00000003, 5'd1,  5'd2,  5'd2,  1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("bgez",  32'h0461FFFF, 4'b1001, 1'b0, 1'b0, 32'hFFFFFFFF, 5'd3,  5'd1,  5'd1,  1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("andi",  32'h31ACF0F0, 4'b0100, 1'b0, 1'b1, 32'h0000F0F0, 5'd13, 5'd12, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("slt",   32'h0043082A, 4'b1011, 1'b0, 1'b0, 32'h00000000, 5'd2,  5'd3,  5'd1,  1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("srav",  32'h00E62807, 4'b1100, 1'b0, 1'b0, 32'h00000000, 5'd7,  5'd6,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("nor",   32'h014B4827, 4'b0111, 1'b0, 1'b0, 32'h00000000, 5'd10, 5'd11, 5'd9,  1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("sltiu", 32'h2C62FFFF, 4'b1010, 1'b0, 1'b1, 32'hFFFFFFFF, 5'd3,  5'd2,  5'd2,  1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("op3f",  32'hFC221821, 4'b0000, 1'b0, 1'b0, 32'h00000000, 5'd1,  5'd2,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk("fn01",  32'h00221801, 4'b0000, 1'b0, 1'b0, 32'h00000000, 5'd1,  5'd2,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk("bltz",  32'h04600005, 4'b0000, 1'b0, 1'b0, 32'h00000000, 5'd3,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk("rd0",   32'h00220021, 4'b0000, 1'b0, 1'b0, 32'h00000000, 5'd1,  5'd2,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0));
        v_lui  = mk("lui",    32'h3C07ABCD, 4'b1000, 1'b0, 1'b1, 32'h0000ABCD, 5'd0,  5'd7,  5'd7,  1'b1, 1'b0, 1'b0, 1'b0);
        v_addu = vecs[0];
        v_hz   = mk("hz_addu", 32'h00411821, 4'b0000, 1'b0, 1'b0, 32'h00000000, 5'd2,  5'd1,  5'd3,  1'b1, 1'b0, 1'b0, 1'b0);
        v_sw   = vecs[5];

        // Reset with a valid word presented: nothing may be captured.
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_instr  = v_addu.instr;
        bus.out_ready = 1'b1;
        bus.flush     = 1'b0;
        bus.ex_load   = 1'b0;
        bus.ex_rd     = 5'd0;
        step();
        step();
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        check("rst_outputs", act_bundle(), 64'd0);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        step();
        check("post_rst_idle", act_bundle(), 64'd0);

        foreach (vecs[i]) begin
            bus.in_valid  = 1'b1;
            bus.in_instr  = vecs[i].instr;
            bus.out_ready = 1'b1;
            step();
            check(vecs[i].name, act_bundle(), exp_bundle(vecs[i]));
        end

        bus.in_valid = 1'b0;
        step();
        check("bubble", {63'd0, bus.out_valid}, 64'd0);

        // Back-pressure: lui held for three cycles while addu waits.
        bus.in_valid  = 1'b1;
        bus.in_instr  = v_lui.instr;
        bus.out_ready = 1'b0;
        step();
        check("lui_capture", act_bundle(), exp_bundle(v_lui));
        bus.in_instr = v_addu.instr;
        for (int c = 0; c < 3; c++) begin
            check("hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
            step();
            check("hold_lui", act_bundle(), exp_bundle(v_lui));
        end
        bus.out_ready = 1'b1;
        #1;
        check("release_in_ready", {63'd0, bus.in_ready}, 64'd1);
        step();
        check("after_hold_addu", act_bundle(), exp_bundle(v_addu));

        // Flush beats a held instruction and drops the presented word.
        bus.flush     = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_instr  = vecs[2].instr;
        bus.out_ready = 1'b0;
        #1;
        check("flush_in_ready", {63'd0, bus.in_ready}, 64'd1);
        step();
        check("flush_valid", {63'd0, bus.out_valid}, 64'd0);
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check("flush_dropped", {63'd0, bus.out_valid}, 64'd0);

        // Load in EX writing $2 while addu $3,$2,$1 waits.
        bus.ex_load  = 1'b1;
        bus.ex_rd    = 5'd2;
        bus.in_valid = 1'b1;
        bus.in_instr = v_hz.instr;
        #1;
`ifdef ID_LOAD_USE_STALL_EN
        check("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            check("stall_valid", {63'd0, bus.out_valid}, 64'd0);
            check("stall_in_ready_hold", {63'd0, bus.in_ready}, 64'd0);
        end
        bus.ex_load = 1'b0;
        #1;
        check("unstall_in_ready", {63'd0, bus.in_ready}, 64'd1);
`else
        check("nostall_in_ready", {63'd0, bus.in_ready}, 64'd1);
`endif
        step();
        check("hazard_accept", act_bundle(), exp_bundle(v_hz));

        // Reset while an instruction is held and the next one is blocked.
        bus.ex_load   = 1'b0;
        bus.in_instr  = v_sw.instr;
        step();
        check("sw_capture", act_bundle(), exp_bundle(v_sw));
        bus.out_ready = 1'b0;
        bus.ex_load   = 1'b1;
        bus.ex_rd     = 5'd29;
        rst           = 1'b1;
        #1;
        check("midrst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        step();
        check("midrst_outputs", act_bundle(), 64'd0);
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.ex_load   = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check("midrst_idle", act_bundle(), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
